// File: rtl/seq_divider.sv
// Multi-cycle restoring integer divider, one quotient bit per cycle.
// Signed/unsigned per operation, with early completion on divide-by-zero and signed overflow.
//
// state | meaning
// IDLE  | waiting for start after reset
// CALC  | restoring steps; also the single cycle spent on a zero-divisor or overflow operation
// FIXUP | apply result signs and register outputs
// DONE  | results valid and held; a new start is accepted here
module seq_divider #(
  parameter int WIDTH = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [WIDTH-1:0] dividend,
  input  logic [WIDTH-1:0] divisor,
  input  logic             is_signed,
  output logic             busy,
  output logic             ready,
  output logic [WIDTH-1:0] quotient,
  output logic [WIDTH-1:0] remainder,
  output logic             div_by_zero,
  output logic             overflow
);

  localparam int CW = $clog2(WIDTH + 1);
  localparam logic [WIDTH-1:0] MOST_NEG = {1'b1, {(WIDTH-1){1'b0}}};

  typedef enum logic [1:0] {IDLE, CALC, FIXUP, DONE} state_t;

  state_t           state_q, state_d;
  logic [WIDTH-1:0] dvd_q, dvd_d;
  logic [WIDTH:0]   rem_q, rem_d;
  logic [WIDTH-1:0] dvs_q, dvs_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic             neg_quo_q, neg_quo_d;
  logic             neg_rem_q, neg_rem_d;
  logic             dbz_pend_q, dbz_pend_d;
  logic             ovf_pend_q, ovf_pend_d;
  logic             busy_q, busy_d;
  logic             ready_q, ready_d;
  logic [WIDTH-1:0] quo_q, quo_d;
  logic [WIDTH-1:0] rmd_q, rmd_d;
  logic             dbz_q, dbz_d;
  logic             ovf_q, ovf_d;

  logic             a_neg, b_neg, zero_div, sgn_ovf;
  logic [WIDTH-1:0] a_mag, b_mag;
  logic [WIDTH+1:0] trial, diff;

  always_comb begin
    a_neg    = is_signed & dividend[WIDTH-1];
    b_neg    = is_signed & divisor[WIDTH-1];
    a_mag    = a_neg ? -dividend : dividend;
    b_mag    = b_neg ? -divisor : divisor;
    zero_div = (divisor == '0);
    sgn_ovf  = is_signed & (dividend == MOST_NEG) & (divisor == '1);
  end

  // Extra top bit keeps the trial subtraction sign visible beyond the WIDTH+1 remainder.
  always_comb begin
    trial = {rem_q, dvd_q[WIDTH-1]};
    diff  = trial - {2'b00, dvs_q};
  end

  always_comb begin
    state_d    = state_q;
    dvd_d      = dvd_q;
    rem_d      = rem_q;
    dvs_d      = dvs_q;
    cnt_d      = cnt_q;
    neg_quo_d  = neg_quo_q;
    neg_rem_d  = neg_rem_q;
    dbz_pend_d = dbz_pend_q;
    ovf_pend_d = ovf_pend_q;
    busy_d     = busy_q;
    ready_d    = ready_q;
    quo_d      = quo_q;
    rmd_d      = rmd_q;
    dbz_d      = dbz_q;
    ovf_d      = ovf_q;

    case (state_q)
      IDLE, DONE: begin
        if (start) begin
          // Early-completion cases keep the raw dividend; it is returned as-is.
          dvd_d      = (zero_div | sgn_ovf) ? dividend : a_mag;
          dvs_d      = b_mag;
          rem_d      = '0;
          cnt_d      = CW'(WIDTH);
          neg_quo_d  = a_neg ^ b_neg;
          neg_rem_d  = a_neg;
          dbz_pend_d = zero_div;
          ovf_pend_d = ~zero_div & sgn_ovf;
          busy_d     = 1'b1;
          ready_d    = 1'b0;
          dbz_d      = 1'b0;
          ovf_d      = 1'b0;
          state_d    = CALC;
        end
      end
      CALC: begin
        if (dbz_pend_q) begin
          quo_d   = '1;
          rmd_d   = dvd_q;
          dbz_d   = 1'b1;
          busy_d  = 1'b0;
          ready_d = 1'b1;
          state_d = DONE;
        end else if (ovf_pend_q) begin
          quo_d   = dvd_q;
          rmd_d   = '0;
          ovf_d   = 1'b1;
          busy_d  = 1'b0;
          ready_d = 1'b1;
          state_d = DONE;
        end else begin
          dvd_d = {dvd_q[WIDTH-2:0], ~diff[WIDTH+1]};
          rem_d = diff[WIDTH+1] ? trial[WIDTH:0] : diff[WIDTH:0];
          cnt_d = cnt_q - CW'(1);
          if (cnt_q == CW'(1)) begin
            state_d = FIXUP;
          end
        end
      end
      FIXUP: begin
        quo_d   = neg_quo_q ? -dvd_q : dvd_q;
        rmd_d   = neg_rem_q ? -rem_q[WIDTH-1:0] : rem_q[WIDTH-1:0];
        busy_d  = 1'b0;
        ready_d = 1'b1;
        state_d = DONE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q    <= IDLE;
      dvd_q      <= '0;
      rem_q      <= '0;
      dvs_q      <= '0;
      cnt_q      <= '0;
      neg_quo_q  <= 1'b0;
      neg_rem_q  <= 1'b0;
      dbz_pend_q <= 1'b0;
      ovf_pend_q <= 1'b0;
      busy_q     <= 1'b0;
      ready_q    <= 1'b0;
      quo_q      <= '0;
      rmd_q      <= '0;
      dbz_q      <= 1'b0;
      ovf_q      <= 1'b0;
    end else begin
      state_q    <= state_d;
      dvd_q      <= dvd_d;
      rem_q      <= rem_d;
      dvs_q      <= dvs_d;
      cnt_q      <= cnt_d;
      neg_quo_q  <= neg_quo_d;
      neg_rem_q  <= neg_rem_d;
      dbz_pend_q <= dbz_pend_d;
      ovf_pend_q <= ovf_pend_d;
      busy_q     <= busy_d;
      ready_q    <= ready_d;
      quo_q      <= quo_d;
      rmd_q      <= rmd_d;
      dbz_q      <= dbz_d;
      ovf_q      <= ovf_d;
    end
  end

  assign busy        = busy_q;
  assign ready       = ready_q;
  assign quotient    = quo_q;
  assign remainder   = rmd_q;
  assign div_by_zero = dbz_q;
  assign overflow    = ovf_q;

endmodule

// File: tb/tb_seq_divider.sv
// Directed and random checks of seq_divider at WIDTH 16 and 32.
// Expected results are queued at launch and popped when ready rises.
module tb_seq_divider;

  typedef struct {
    logic [63:0] q;
    logic [63:0] r;
    logic        dz;
    logic        ov;
  } exp_t;

  logic clk = 1'b0;
  logic rst;

  logic        st16, sg16, bsy16, rdy16, dz16, ov16;
  logic [15:0] a16, b16, q16, r16;
  logic        st32, sg32, bsy32, rdy32, dz32, ov32;
  logic [31:0] a32, b32, q32, r32;

  int   checks = 0;
  int   errors = 0;
  exp_t sb[$];

  seq_divider #(.WIDTH(16)) u_div16 (
    .clk(clk), .rst(rst), .start(st16), .dividend(a16), .divisor(b16),
    .is_signed(sg16), .busy(bsy16), .ready(rdy16), .quotient(q16),
    .remainder(r16), .div_by_zero(dz16), .overflow(ov16)
  );

  seq_divider #(.WIDTH(32)) u_div32 (
    .clk(clk), .rst(rst), .start(st32), .dividend(a32), .divisor(b32),
    .is_signed(sg32), .busy(bsy32), .ready(rdy32), .quotient(q32),
    .remainder(r32), .div_by_zero(dz32), .overflow(ov32)
  );

  always #5 clk = ~clk;

  function automatic exp_t mk(logic [63:0] q, logic [63:0] r, logic dz, logic ov);
    exp_t e;
    e.q = q; e.r = r; e.dz = dz; e.ov = ov;
    return e;
  endfunction

  function automatic exp_t model(int w, logic [63:0] a, logic [63:0] b, logic s);
    logic [63:0] mask;
    longint      sa, sb_v;
    mask = (64'd1 << w) - 64'd1;
    if (b == 64'd0) return mk(mask, a, 1'b1, 1'b0);
    if (s && a == (64'd1 << (w - 1)) && b == mask) return mk(a, 64'd0, 1'b0, 1'b1);
    if (s) begin
      sa   = $signed(a << (64 - w)) >>> (64 - w);
      sb_v = $signed(b << (64 - w)) >>> (64 - w);
      return mk(64'(sa / sb_v) & mask, 64'(sa % sb_v) & mask, 1'b0, 1'b0);
    end
    return mk(a / b, a % b, 1'b0, 1'b0);
  endfunction

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic set_in(input int w, input logic st, input logic [63:0] a, input logic [63:0] b,
                        input logic s);
    if (w == 16) begin
      st16 = st; a16 = a[15:0]; b16 = b[15:0]; sg16 = s;
    end else begin
      st32 = st; a32 = a[31:0]; b32 = b[31:0]; sg32 = s;
    end
  endtask

  task automatic get_out(input int w, output logic bsy, output logic rdy, output logic [63:0] q,
                         output logic [63:0] r, output logic dz, output logic ov);
    if (w == 16) begin
      bsy = bsy16; rdy = rdy16; q = 64'(q16); r = 64'(r16); dz = dz16; ov = ov16;
    end else begin
      bsy = bsy32; rdy = rdy32; q = 64'(q32); r = 64'(r32); dz = dz32; ov = ov32;
    end
  endtask

  task automatic check_zero(input int w, input string tag);
    logic bsy, rdy, dz, ov;
    logic [63:0] q, r;
    get_out(w, bsy, rdy, q, r, dz, ov);
    chk({tag, "_busy"}, 64'(bsy), 64'd0);
    chk({tag, "_ready"}, 64'(rdy), 64'd0);
    chk({tag, "_q"}, q, 64'd0);
    chk({tag, "_r"}, r, 64'd0);
    chk({tag, "_dbz"}, 64'(dz), 64'd0);
    chk({tag, "_ovf"}, 64'(ov), 64'd0);
  endtask

  // Called at #1 after a posedge; returns at #1 after the accept edge.
  task automatic launch(input int w, input logic [63:0] a, input logic [63:0] b, input logic s,
                        input exp_t e, input string tag);
    logic bsy, rdy, dz, ov;
    logic [63:0] q, r;
    set_in(w, 1'b1, a, b, s);
    sb.push_back(e);
    @(posedge clk);
    #1;
    set_in(w, 1'b0, a, b, s);
    get_out(w, bsy, rdy, q, r, dz, ov);
    chk({tag, "_acc_busy"}, 64'(bsy), 64'd1);
    chk({tag, "_acc_ready"}, 64'(rdy), 64'd0);
    chk({tag, "_acc_flags"}, {62'd0, dz, ov}, 64'd0);
  endtask

  // Waits for ready; lat is the number of edges still expected before ready.
  task automatic finish(input int w, input int lat, input string tag);
    logic bsy, rdy, dz, ov;
    logic [63:0] q, r;
    exp_t e;
    int n = 0;
    int busy_n = 0;
    get_out(w, bsy, rdy, q, r, dz, ov);
    while (!rdy && n < 200) begin
      if (bsy) busy_n++;
      @(posedge clk);
      #1;
      n++;
      get_out(w, bsy, rdy, q, r, dz, ov);
    end
    chk({tag, "_latency"}, 64'(n), 64'(lat));
    chk({tag, "_busy_cycles"}, 64'(busy_n), 64'(lat));
    chk({tag, "_busy_done"}, 64'(bsy), 64'd0);
    if (sb.size() == 0) begin
      chk({tag, "_scoreboard"}, 64'd0, 64'd1);
    end else begin
      e = sb.pop_front();
      chk({tag, "_q"}, q, e.q);
      chk({tag, "_r"}, r, e.r);
      chk({tag, "_dbz"}, 64'(dz), 64'(e.dz));
      chk({tag, "_ovf"}, 64'(ov), 64'(e.ov));
    end
  endtask

  task automatic op(input int w, input logic [63:0] a, input logic [63:0] b, input logic s,
                    input exp_t e, input int lat, input string tag);
    launch(w, a, b, s, e, tag);
    finish(w, lat, tag);
  endtask

  initial begin
    logic bsy, rdy, dz, ov;
    logic [63:0] q, r, a, b;
    logic s;
    exp_t e;

    rst = 1'b0;
    set_in(16, 1'b0, 64'd0, 64'd0, 1'b0);
    set_in(32, 1'b0, 64'd0, 64'd0, 1'b0);
    repeat (2) @(posedge clk);
    #1;
    check_zero(16, "rst16");
    check_zero(32, "rst32");
    rst = 1'b1;
    @(posedge clk);
    #1;

    op(16, 64'd100, 64'd7, 1'b0, mk(64'd14, 64'd2, 1'b0, 1'b0), 17, "u100_7");
    op(16, 64'hFF9C, 64'h0007, 1'b1, mk(64'hFFF2, 64'hFFFE, 1'b0, 1'b0), 17, "sm100_7");
    op(16, 64'h0064, 64'hFFF9, 1'b1, mk(64'hFFF2, 64'h0002, 1'b0, 1'b0), 17, "s100_m7");
    op(16, 64'd1234, 64'd0, 1'b0, mk(64'hFFFF, 64'h04D2, 1'b1, 1'b0), 1, "dbz_u");
    op(16, 64'd1234, 64'd0, 1'b1, mk(64'hFFFF, 64'h04D2, 1'b1, 1'b0), 1, "dbz_s");
    op(16, 64'd0, 64'd0, 1'b0, mk(64'hFFFF, 64'h0000, 1'b1, 1'b0), 1, "dbz_0_0");
    op(16, 64'h8000, 64'hFFFF, 1'b1, mk(64'h8000, 64'h0000, 1'b0, 1'b1), 1, "ovf_s");
    op(16, 64'h8000, 64'hFFFF, 1'b0, mk(64'h0000, 64'h8000, 1'b0, 1'b0), 17, "ovf_u");

    // Start pulsed mid-CALC with other operands must be ignored.
    launch(16, 64'd1000, 64'd3, 1'b0, mk(64'd333, 64'd1, 1'b0, 1'b0), "ignore");
    repeat (4) @(posedge clk);
    #1;
    set_in(16, 1'b1, 64'd5, 64'd5, 1'b0);
    @(posedge clk);
    #1;
    set_in(16, 1'b0, 64'd5, 64'd5, 1'b0);
    finish(16, 12, "ignore");

    // Start held high across DONE: second operation starts on the first DONE edge.
    set_in(16, 1'b1, 64'd50000, 64'd300, 1'b0);
    sb.push_back(mk(64'd166, 64'd200, 1'b0, 1'b0));
    @(posedge clk);
    #1;
    set_in(16, 1'b1, 64'hFF01, 64'h0010, 1'b1);
    sb.push_back(mk(64'hFFF1, 64'hFFF1, 1'b0, 1'b0));
    finish(16, 17, "b2b_a");
    @(posedge clk);
    #1;
    set_in(16, 1'b0, 64'hFF01, 64'h0010, 1'b1);
    get_out(16, bsy, rdy, q, r, dz, ov);
    chk("b2b_ready_drop", 64'(rdy), 64'd0);
    chk("b2b_busy_rise", 64'(bsy), 64'd1);
    finish(16, 17, "b2b_b");

    // Asynchronous reset during CALC.
    launch(16, 64'd100, 64'd7, 1'b0, mk(64'd14, 64'd2, 1'b0, 1'b0), "pre_rst");
    repeat (4) @(posedge clk);
    #1;
    rst = 1'b0;
    #1;
    check_zero(16, "midrst16");
    sb.delete();
    @(posedge clk);
    #1;
    rst = 1'b1;
    op(16, 64'd65535, 64'd1, 1'b0, mk(64'hFFFF, 64'h0000, 1'b0, 1'b0), 17, "post_rst");

    op(32, 64'd100, 64'd7, 1'b0, mk(64'd14, 64'd2, 1'b0, 1'b0), 33, "w32_u");
    op(32, 64'hFFFF_FF9C, 64'd7, 1'b1, mk(64'hFFFF_FFF2, 64'hFFFF_FFFE, 1'b0, 1'b0), 33, "w32_s");
    op(32, 64'h8000_0000, 64'hFFFF_FFFF, 1'b1, mk(64'h8000_0000, 64'd0, 1'b0, 1'b1), 1, "w32_ovf");
    op(32, 64'd7, 64'd0, 1'b1, mk(64'hFFFF_FFFF, 64'd7, 1'b1, 1'b0), 1, "w32_dbz");
    for (int i = 0; i < 40; i++) begin
      a = 64'($urandom);
      b = ($urandom_range(0, 3) == 0) ? 64'($urandom_range(0, 20)) : 64'($urandom);
      if ($urandom_range(0, 7) == 0) b = 64'hFFFF_FFFF;
      s = 1'($urandom_range(0, 1));
      e = model(32, a, b, s);
      op(32, a, b, s, e, (e.dz || e.ov) ? 1 : 33, "w32_rand");
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/seq_divider.md
# seq_divider

Parametrised multi-cycle integer divider, the successor to the fixed 16-bit start/ready divider. It computes quotient and remainder of a WIDTH-bit dividend and divisor by restoring division, one quotient bit per cycle. It adds per-operation signed/unsigned mode, divide-by-zero and signed-overflow detection with early completion, and a busy indication. It sits as a shared arithmetic unit behind a simple start/ready handshake.

## Interface

- WIDTH, 16: operand and result width in bits; legal range 4–64.
- clk  input  1  clock; all state updates on the rising edge.
- rst  input  1  asynchronous, active-low reset.
- start  input  1  request; sampled only when the block is not busy.
- dividend  input  WIDTH  dividend; captured on an accepted start.
- divisor  input  WIDTH  divisor; captured on an accepted start.
- is_signed  input  1  1 selects two's-complement division; captured on an accepted start.
- busy  output  1  high while an accepted operation is in progress.
- ready  output  1  high when results are valid; held until the next accepted start.
- quotient  output  WIDTH  quotient result.
- remainder  output  WIDTH  remainder result.
- div_by_zero  output  1  divisor was zero; valid while ready.
- overflow  output  1  signed most-negative / −1; valid while ready.

## Operation

- States are IDLE, CALC, FIXUP and DONE. Start is accepted in IDLE or DONE.
- On an accepted start:
  - Capture the operands and mode.
  - Clear ready, div_by_zero and overflow.
  - In signed mode, take the absolute values of the operands and record both sign bits.
  - Load the iteration counter with WIDTH and go to CALC.
- Divide-by-zero takes priority over overflow. When the divisor is 0 at start, go directly to DONE with:
  - quotient = all ones
  - remainder = dividend (raw, unmodified)
  - div_by_zero = 1
- Signed overflow applies when is_signed = 1, dividend = 1 followed by zeros, and divisor = all ones. Go directly to DONE with:
  - quotient = dividend
  - remainder = 0
  - overflow = 1
- CALC performs one restoring step per cycle:
  - Shift {partial remainder, dividend} left by 1 and trial-subtract the divisor magnitude.
  - The quotient bit is 1 if the result is non-negative, and the partial remainder is then replaced by the difference.
  - The partial remainder register is WIDTH+1 bits.
  - After WIDTH steps, go to FIXUP.
- FIXUP applies signs in signed mode, then goes to DONE and registers the outputs:
  - Negate the quotient if the operand signs differ.
  - Negate the remainder if the dividend was negative.
  - Quotient truncates toward zero; the remainder takes the dividend's sign.
- DONE: ready = 1. Outputs are held stable until the next accepted start.
- A start asserted while busy is ignored: no capture and no effect on the current operation.
- Reset, asynchronous and at any time including mid-operation:
  - State returns to IDLE.
  - busy, ready, quotient, remainder, div_by_zero and overflow are all 0.
  - Internal registers are 0.
  - After reset is released, the next accepted start behaves as from power-up.

## Timing

- Start sampled high at rising edge k in IDLE or DONE:
  - busy = 1 and ready = 0 after edge k.
  - Normal path: CALC covers edges k+1 to k+WIDTH, FIXUP is at edge k+WIDTH+1, and ready = 1 with busy = 0 after edge k+WIDTH+1. Latency is WIDTH+1 cycles (17 for WIDTH = 16).
  - Early paths (zero divisor or overflow): ready = 1 after edge k+1, busy is high for exactly 1 cycle, and results appear at that same edge.
- Back-to-back: start may be held high in DONE. It is accepted at the first DONE edge, and ready drops the cycle after that edge.
- Outputs are registered; there are no combinational paths from inputs to outputs.

## Test plan

- Unsigned, WIDTH = 16, 100 / 7: quotient 14 and remainder 2; ready rises exactly 17 cycles after start; busy is high for those 17 cycles.
- Signed, −100 / 7 (0xFF9C / 0x0007): quotient 0xFFF2 and remainder 0xFFFE. Also run 100 / −7: quotient 0xFFF2 and remainder 0x0002.
- Divide-by-zero, 1234 / 0 in both modes: quotient 0xFFFF, remainder 0x04D2, div_by_zero = 1, ready after 1 cycle. Also 0 / 0: quotient 0xFFFF, remainder 0, div_by_zero = 1.
- Signed overflow, 0x8000 / 0xFFFF: quotient 0x8000, remainder 0, overflow = 1, ready after 1 cycle. The same operands unsigned give quotient 0, remainder 0x8000 and the full 17-cycle latency.
- Start pulsed again mid-CALC with different operands: ignored, and the original result is delivered on schedule. Then start held high across DONE: the second operation is accepted and both results are checked.
- rst asserted at cycle 5 of CALC: all outputs go to 0 immediately. After release, a new 65535 / 1 yields quotient 0xFFFF and remainder 0. Repeat with WIDTH = 32, including random signed/unsigned operands checked against a reference model.
